// File: rtl/lumi_syncfifo_pkg.sv
// Shared LUMI constants used by the same-clock UMI buffering blocks.
package lumi_syncfifo_pkg;

  localparam int UMI_DW = 256;

endpackage

// File: rtl/la_syncfifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module la_syncfifo_mem #(
  parameter int DW    = 256,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately unreset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lumi_syncfifo.sv
// Single-clock UMI FIFO with first-word-fall-through output, occupancy,
// almost-full, synchronous flush and a combinational bypass mode.
module lumi_syncfifo
  import lumi_syncfifo_pkg::*;
#(
  parameter int DW    = UMI_DW,
  parameter int DEPTH = 4,
  parameter int AFULL = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bypass,
  input  logic          flush,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_afull,
  output logic [AW:0]   fifo_count,
  input  logic          umi_in_valid,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready
);

  // Handshake: a word transfers on a clock edge exactly when valid and ready
  // are both high; valid never waits on ready, and data is held while valid.

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] rd_data;
  logic          push;
  logic          pop;

  // Flags come only from the registered count.
  assign fifo_count = count;
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_afull = (count >= (AW+1)'(AFULL));

  assign umi_in_ready  = bypass ? (umi_out_ready & ~reset)
                                : (~fifo_full & ~flush & ~reset);
  assign umi_out_valid = bypass ? umi_in_valid : ~fifo_empty;
  assign umi_out_data  = bypass ? umi_in_data  : rd_data;

  // Storage state is frozen while bypassed.
  assign push = ~bypass & umi_in_valid & umi_in_ready;
  assign pop  = ~bypass & ~fifo_empty & umi_out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  la_syncfifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (umi_in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
